// File: rtl/watchdog_pkg.sv
// Shared definitions for the byte-serial result link between output_loader
// and result_receiver.
package watchdog_pkg;

  localparam logic [3:0] MARKER    = 4'hA;
  localparam int         FRAME_LEN = 10;

  // Regime code shared with eig_core/output_loader.
  typedef logic [2:0] regime_t;

  typedef enum logic [1:0] {
    IDLE,
    WORD_A,
    WORD_B,
    CHECK
  } rx_state_t;

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter: clears on demand, counts while enabled, and flags the
// enabled cycle in which the count reaches LIMIT.
module frame_timer #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count;

  // This idle cycle is the one that brings the count up to LIMIT.
  assign expired = enable && (count == WIDTH'(LIMIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/result_receiver.sv
// Receiver for the 10-byte result frame: hunts for the header, reassembles
// mode/word_a/word_b, verifies the XOR checksum and aborts on idle timeout.
module result_receiver
  import watchdog_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [3:0] MARKER      = watchdog_pkg::MARKER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [2:0]  mode,
  output logic [31:0] word_a,
  output logic [31:0] word_b,
  output logic        res_valid,
  output logic        frame_err,
  output logic        busy
);

  rx_state_t   state;
  regime_t     mode_sh;
  logic [31:0] word_a_sh;
  logic [31:0] word_b_sh;
  logic [7:0]  acc;
  logic [1:0]  idx;
  logic        timer_expired;
  logic        is_header;

  assign is_header = (rx_byte[7:4] == MARKER) && !rx_byte[3];

  // The timer only runs inside a frame; any accepted byte restarts it.
  frame_timer #(
    .WIDTH (16),
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == IDLE) || rx_valid),
    .enable  ((state != IDLE) && !rx_valid),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_sh   <= '0;
      word_a_sh <= '0;
      word_b_sh <= '0;
      acc       <= '0;
      idx       <= '0;
      mode      <= '0;
      word_a    <= '0;
      word_b    <= '0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_valid && is_header) begin
            mode_sh <= rx_byte[2:0];
            acc     <= rx_byte;
            idx     <= '0;
            state   <= WORD_A;
            busy    <= 1'b1;
          end
        end

        WORD_A, WORD_B: begin
          if (rx_valid) begin
            if (state == WORD_A) word_a_sh <= {word_a_sh[23:0], rx_byte};
            else                 word_b_sh <= {word_b_sh[23:0], rx_byte};
            acc <= acc ^ rx_byte;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= (state == WORD_A) ? WORD_B : CHECK;
            end
          end else if (timer_expired) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            word_a_sh <= '0;
            word_b_sh <= '0;
          end
        end

        CHECK: begin
          if (rx_valid) begin
            if (rx_byte == acc) begin
              mode      <= mode_sh;
              word_a    <= word_a_sh;
              word_b    <= word_b_sh;
              res_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer_expired) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            word_a_sh <= '0;
            word_b_sh <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_receiver.sv
// Directed bench for result_receiver: a table of whole frames plus
// hand-written hunt, timeout, byte-wins and mid-frame reset sequences.
module tb_result_receiver;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [2:0]  mode;
  logic [31:0] word_a;
  logic [31:0] word_b;
  logic        res_valid;
  logic        frame_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  result_receiver #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .mode      (mode),
    .word_a    (word_a),
    .word_b    (word_b),
    .res_valid (res_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] bytes;   // byte 0 in [79:72]
    int          gap;     // idle cycles between bytes
    logic        ok;      // checksum good
    logic [2:0]  exp_mode;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } frame_vec_t;

  localparam logic [79:0] NOMINAL = 80'hA2_00_01_80_00_00_00_AA_AA_23;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [79:0] bytes, input int gap);
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[79-8*i -: 8]);
      if (i == 0) check("busy_after_header", {31'd0, busy}, 32'd1);
      if (i != 9) idle(gap);
    end
  endtask

  task automatic check_decode(input string name, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] b);
    check({name, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({name, "_mode"}, {29'd0, mode}, {29'd0, m});
    check({name, "_word_a"}, word_a, a);
    check({name, "_word_b"}, word_b, b);
  endtask

  frame_vec_t vecs[5];

  initial begin
    // A5 FF FF FF FF 80 00 00 00 XORs to 0x25; 0xDA is a deliberately bad checksum.
    vecs[0] = '{80'hA2_00_01_80_00_00_00_AA_AA_24, 0, 1'b0, 3'd0, 32'h0, 32'h0};
    vecs[1] = '{NOMINAL, 0, 1'b1, 3'b010, 32'h0001_8000, 32'h0000_AAAA};
    vecs[2] = '{80'hA5_FF_FF_FF_FF_80_00_00_00_25, 1, 1'b1, 3'b101, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3] = '{80'hA2_00_01_80_00_00_00_AA_AA_DA, 1, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[4] = '{NOMINAL, 0, 1'b1, 3'b010, 32'h0001_8000, 32'h0000_AAAA};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(3);
    rst = 1'b0;
    @(negedge clk);

    check("reset_mode", {29'd0, mode}, 32'd0);
    check("reset_word_a", word_a, 32'd0);
    check("reset_word_b", word_b, 32'd0);
    check("reset_flags", {29'd0, res_valid, frame_err, busy}, 32'd0);

    // Table of frames, applied back to back (next header lands while the
    // previous res_valid/frame_err pulse is still high).
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].bytes, vecs[v].gap);
      check($sformatf("vec%0d_res_valid", v), {31'd0, res_valid}, {31'd0, vecs[v].ok});
      check($sformatf("vec%0d_frame_err", v), {31'd0, frame_err}, {31'd0, !vecs[v].ok});
      check($sformatf("vec%0d_mode", v), {29'd0, mode}, {29'd0, vecs[v].exp_mode});
      check($sformatf("vec%0d_word_a", v), word_a, vecs[v].exp_a);
      check($sformatf("vec%0d_word_b", v), word_b, vecs[v].exp_b);
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end
    idle(1);
    check("pulse_one_cycle", {30'd0, res_valid, frame_err}, 32'd0);

    // Hunt: non-header bytes are dropped without error.
    send_byte(8'h55);
    check("hunt_55_busy", {30'd0, busy, frame_err}, 32'd0);
    send_byte(8'h3F);
    check("hunt_3F_busy", {30'd0, busy, frame_err}, 32'd0);
    send_byte(8'hB2);
    check("hunt_B2_busy", {30'd0, busy, frame_err}, 32'd0);
    send_frame(NOMINAL, 0);
    check_decode("hunt", 3'b010, 32'h0001_8000, 32'h0000_AAAA);
    idle(2);

    // Timeout: abort after exactly TO idle cycles inside a frame.
    send_byte(8'hA2);
    send_byte(8'h00);
    send_byte(8'h01);
    idle(TO - 1);
    check("to_before_busy", {31'd0, busy}, 32'd1);
    check("to_before_err", {31'd0, frame_err}, 32'd0);
    idle(1);
    check("to_expiry_err", {31'd0, frame_err}, 32'd1);
    check("to_expiry_busy", {31'd0, busy}, 32'd0);
    check("to_keeps_word_a", word_a, 32'h0001_8000);
    idle(1);
    check("to_err_pulse", {31'd0, frame_err}, 32'd0);
    send_frame(NOMINAL, 0);
    check_decode("after_to", 3'b010, 32'h0001_8000, 32'h0000_AAAA);
    idle(2);

    // Byte arriving on the would-be expiry cycle is accepted.
    send_byte(8'hA2);
    send_byte(8'h00);
    idle(TO - 1);
    send_byte(8'h01);
    check("byte_wins_err", {31'd0, frame_err}, 32'd0);
    check("byte_wins_busy", {31'd0, busy}, 32'd1);
    for (int i = 3; i < 10; i++) send_byte(NOMINAL[79-8*i -: 8]);
    check_decode("byte_wins", 3'b010, 32'h0001_8000, 32'h0000_AAAA);
    idle(2);

    // Load distinct values, then reset mid-frame after byte 5.
    send_frame(vecs[2].bytes, 0);
    check_decode("pre_rst", 3'b101, 32'hFFFF_FFFF, 32'h8000_0000);
    for (int i = 0; i < 5; i++) send_byte(NOMINAL[79-8*i -: 8]);
    rst = 1'b1;
    idle(1);
    check("rst_mode", {29'd0, mode}, 32'd0);
    check("rst_word_a", word_a, 32'd0);
    check("rst_word_b", word_b, 32'd0);
    check("rst_flags", {29'd0, res_valid, frame_err, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 5; i < 10; i++) begin
      send_byte(NOMINAL[79-8*i -: 8]);
      check($sformatf("rst_tail%0d", i), {29'd0, res_valid, frame_err, busy}, 32'd0);
    end
    send_frame(NOMINAL, 0);
    check_decode("after_rst", 3'b010, 32'h0001_8000, 32'h0000_AAAA);
    idle(1);
    check("final_idle", {29'd0, res_valid, frame_err, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
